uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the 65c02 SoC, successor to the fixed 8N1 receive path. It adds configurable data width, parity, stop bits and oversampling, majority-vote bit sampling, false-start rejection, sticky error flags and a show-ahead receive FIFO. It sits between the top-level rx pin and the CPU-facing I/O register block, which pops bytes through rd_en.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, minimum 8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, power of 2, minimum 2

Ports:
clk  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous, active-low reset
rx  in  1  serial input, asynchronous to clk, idle high
rd_en  in  1  pop request; ignored when empty=1
rd_data  out  DATA_BITS  FIFO head; valid while empty=0
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  out  1  frame in progress (state != IDLE)
parity_err  out  1  sticky flag
frame_err  out  1  sticky flag
overrun  out  1  sticky flag
err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, FIFO pointers=0, empty=1, full=0, count=0, rd_data=0, busy=0, all flags=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick generator: DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded to nearest; 27 at the defaults. The tick counter resets to 0 on start-edge detection.
- Bit decision: 2-of-3 majority of samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- IDLE: a falling edge on the synchronised rx moves to START.
- START: if the bit decision is 1, treat as a false start and return to IDLE; otherwise go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Next state is PARITY if PARITY != 0, else STOP.
- PARITY: compare the received bit with the computed parity. Odd: data plus parity bit contain an odd number of 1s. Even: the count of 1s is even.
- STOP: sample STOP_BITS stop bits.
  - Any stop bit = 0: frame_err=1, byte discarded, state=BREAK.
  - All stop bits = 1: push the byte, return to IDLE.
- BREAK: remain until synchronised rx=1, then IDLE.
- Push timing: the push takes effect on the clk edge after the final stop-bit decision; empty falls on that edge.
- Parity error: the byte is still pushed and parity_err=1.
- Overrun: a push while full and with no simultaneous pop drops the new byte; overrun=1; FIFO contents unchanged.
- Simultaneous push and pop:
  - When full: both succeed; count unchanged.
  - When empty: the pop is ignored and the push succeeds.
- rd_data shows the FIFO head combinationally from registered storage; it updates on the edge after a pop.
- Pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH).
- err_clr and a new error in the same cycle: the set wins.
- RST asserted mid-frame aborts the frame and clears the FIFO; after release, the next falling edge starts a fresh frame.
- The receiver must tolerate a baud mismatch of ±2% with the default parameters.

Test Plan:
1. Default params; after reset, drive 0x18 as 8N1 at 8681 ns/bit (bits 0,0,0,1,1,0,0,0, stop 1) -> empty=0, rd_data=0x18, count=1, flags=0. Pulse rd_en -> empty=1, count=0.
2. Drive rx low for 2000 ns, then high -> busy returns to 0 after the START sample, FIFO stays empty, no flags set.
3. Send 0x18 with stop bit = 0, hold low 20 µs, release, then send 0x55 -> frame_err=1, 0x18 not stored, 0x55 is the only entry (count=1).
4. Send 0x00..0x0F without reading, then 0xAA -> full=1, overrun=1, 16 pops return 0x00..0x0F in order. err_clr -> overrun=0.
5. PARITY=2, send 0x18 with parity bit 1 -> rd_data=0x18, parity_err=1. Send 0x18 with parity bit 0 -> no new error.
6. Assert RST during data bit 3 of a frame -> all outputs at reset values. After release, send 0x18 at a bit period of 8507 ns (+2% rate) -> rd_data=0x18, no flags.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with majority-vote sampling and show-ahead receive FIFO
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic [SW-1:0]          smp_cnt_q, smp_cnt_d;
  logic                   smp0_q, smp0_d, smp1_q, smp1_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   push_q, push_d;
  logic [DATA_BITS-1:0]   push_data_q, push_data_d;
  logic                   tick, decide, vote, par_exp, par_set, fe_set;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                   do_push, do_pop, ov_set;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      smp0_q      <= 1'b1;
      smp1_q      <= 1'b1;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      div_cnt_q   <= div_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      smp0_q      <= smp0_d;
      smp1_q      <= smp1_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  // Every bit is decided on the third mid-bit sample; the tick phase keeps running so the
  // next decision lands one full bit later.
  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    decide      = tick && (smp_cnt_q == SMP_C);
    vote        = (smp0_q & smp1_q) | (smp0_q & rx_s2_q) | (smp1_q & rx_s2_q);
    par_exp     = (PARITY == 1) ? ~(^shreg_q) : ^shreg_q;
    state_d     = state_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    smp_cnt_d   = smp_cnt_q;
    smp0_d      = smp0_q;
    smp1_d      = smp1_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    par_set     = 1'b0;
    fe_set      = 1'b0;
    if (tick) begin
      smp_cnt_d = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
      if (smp_cnt_q == SMP_A) smp0_d = rx_s2_q;
      if (smp_cnt_q == SMP_B) smp1_d = rx_s2_q;
    end
    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        smp_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (decide) begin
          state_d   = vote ? S_IDLE : S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (decide) begin
          shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_set    = (vote != par_exp);
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (decide) begin
          if (!vote) begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end else if (stop_cnt_q == STOP_LAST) begin
            push_d      = 1'b1;
            push_data_d = shreg_q;
            state_d     = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        div_cnt_d = '0;
        smp_cnt_d = '0;
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_pop   = rd_en && !empty;
    do_push  = push_q && (!full || do_pop);
    ov_set   = push_q && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as err_clr must survive.
    pe_d = (pe_q && !err_clr) || par_set;
    fe_d = (fe_q && !err_clr) || fe_set;
    ov_d = (ov_q && !err_clr) || ov_set;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_q;
  end

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign count      = count_q;
  assign rd_data    = empty ? '0 : mem[rd_ptr_q];
  assign busy       = (state_q != S_IDLE);
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized bench for uart_rx_fifo against a queue-based frame model
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT_A = 8681;
  localparam int BIT_C = 2240;

  logic       clk = 1'b0;
  logic       RST;
  logic       rxl [3];
  logic       rd  [3];
  logic       ecl [3];
  logic [7:0] rdat [3];
  logic [4:0] cnt  [3];
  logic       emp [3], ful [3], bsy [3], pe_o [3], fe_o [3], ov_o [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  logic [7:0] mq2 [$];
  bit         mpe [3], mfe [3], mov [3];

  always #10 clk = ~clk;

  uart_rx_fifo u0 (
    .clk(clk), .RST(RST), .rx(rxl[0]), .rd_en(rd[0]), .rd_data(rdat[0]), .empty(emp[0]),
    .full(ful[0]), .count(cnt[0]), .busy(bsy[0]), .parity_err(pe_o[0]), .frame_err(fe_o[0]),
    .overrun(ov_o[0]), .err_clr(ecl[0]));

  uart_rx_fifo #(.PARITY(2)) u1 (
    .clk(clk), .RST(RST), .rx(rxl[1]), .rd_en(rd[1]), .rd_data(rdat[1]), .empty(emp[1]),
    .full(ful[1]), .count(cnt[1]), .busy(bsy[1]), .parity_err(pe_o[1]), .frame_err(fe_o[1]),
    .overrun(ov_o[1]), .err_clr(ecl[1]));

  uart_rx_fifo #(.BAUD(460800)) u2 (
    .clk(clk), .RST(RST), .rx(rxl[2]), .rd_en(rd[2]), .rd_data(rdat[2]), .empty(emp[2]),
    .full(ful[2]), .count(cnt[2]), .busy(bsy[2]), .parity_err(pe_o[2]), .frame_err(fe_o[2]),
    .overrun(ov_o[2]), .err_clr(ecl[2]));

  function automatic int msize(input int i);
    case (i)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  function automatic logic [7:0] mhead(input int i);
    if (msize(i) == 0) return 8'h00;
    case (i)
      0:       return mq0[0];
      1:       return mq1[0];
      default: return mq2[0];
    endcase
  endfunction

  task automatic m_push(input int i, input logic [7:0] d);
    if (msize(i) == 16) mov[i] = 1'b1;
    else case (i)
      0:       mq0.push_back(d);
      1:       mq1.push_back(d);
      default: mq2.push_back(d);
    endcase
  endtask

  task automatic m_pop(input int i);
    if (msize(i) > 0) case (i)
      0:       void'(mq0.pop_front());
      1:       void'(mq1.pop_front());
      default: void'(mq2.pop_front());
    endcase
  endtask

  task automatic m_reset();
    mq0.delete(); mq1.delete(); mq2.delete();
    for (int i = 0; i < 3; i++) begin
      mpe[i] = 1'b0; mfe[i] = 1'b0; mov[i] = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int i, input string tag);
    check({tag, ".empty"},   32'(emp[i]),  32'(msize(i) == 0));
    check({tag, ".full"},    32'(ful[i]),  32'(msize(i) == 16));
    check({tag, ".count"},   32'(cnt[i]),  32'(msize(i)));
    check({tag, ".rd_data"}, 32'(rdat[i]), 32'(mhead(i)));
    check({tag, ".par_err"}, 32'(pe_o[i]), 32'(mpe[i]));
    check({tag, ".frm_err"}, 32'(fe_o[i]), 32'(mfe[i]));
    check({tag, ".overrun"}, 32'(ov_o[i]), 32'(mov[i]));
    check({tag, ".busy"},    32'(bsy[i]),  32'd0);
  endtask

  // Expected outcome follows the frame rules: bad stop discards, bad parity still stores.
  task automatic send(input int i, input logic [7:0] d, input int par_mode, input logic par_bit,
                      input logic stop_v, input int bit_ns);
    rxl[i] = 1'b0;
    #(bit_ns);
    for (int b = 0; b < 8; b++) begin
      rxl[i] = d[b];
      #(bit_ns);
    end
    if (par_mode != 0) begin
      rxl[i] = par_bit;
      #(bit_ns);
    end
    rxl[i] = stop_v;
    #(bit_ns);
    if (!stop_v) mfe[i] = 1'b1;
    else begin
      if (par_mode != 0 && ((^d ^ par_bit) != (par_mode == 1))) mpe[i] = 1'b1;
      m_push(i, d);
      #(bit_ns / 2);
    end
  endtask

  task automatic pop(input int i);
    @(negedge clk); rd[i] = 1'b1;
    @(negedge clk); rd[i] = 1'b0;
    m_pop(i);
  endtask

  task automatic clr(input int i);
    @(negedge clk); ecl[i] = 1'b1;
    @(negedge clk); ecl[i] = 1'b0;
    mpe[i] = 1'b0; mfe[i] = 1'b0; mov[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input string tag);
    for (int k = 0; k < 2000 && bsy[i]; k++) @(negedge clk);
    check(tag, 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       sv;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxl[i] = 1'b1; rd[i] = 1'b0; ecl[i] = 1'b0;
    end
    m_reset();
    repeat (3) @(negedge clk);
    chk_all(0, "reset");
    RST = 1'b1;
    repeat (5) @(negedge clk);

    send(0, 8'h18, 0, 1'b0, 1'b1, BIT_A);
    @(negedge clk); chk_all(0, "t1");
    pop(0);
    @(negedge clk); chk_all(0, "t1_pop");

    rxl[0] = 1'b0;
    #1000;
    @(negedge clk); check("t2.busy_hi", 32'(bsy[0]), 32'd1);
    #1000;
    rxl[0] = 1'b1;
    wait_idle(0, "t2.busy_lo");
    chk_all(0, "t2");

    send(0, 8'h18, 0, 1'b0, 1'b0, BIT_A);
    #20000;
    rxl[0] = 1'b1;
    #(2 * BIT_A);
    send(0, 8'h55, 0, 1'b0, 1'b1, BIT_A);
    @(negedge clk); chk_all(0, "t3");

    for (int v = 0; v < 16; v++) send(2, 8'(v), 0, 1'b0, 1'b1, BIT_C);
    @(negedge clk); chk_all(2, "t4_full");
    send(2, 8'hAA, 0, 1'b0, 1'b1, BIT_C);
    @(negedge clk); chk_all(2, "t4_ovr");
    for (int v = 0; v < 16; v++) begin
      @(negedge clk); check("t4.pop_data", 32'(rdat[2]), 32'(mhead(2)));
      pop(2);
    end
    @(negedge clk); chk_all(2, "t4_drained");
    clr(2);
    @(negedge clk); chk_all(2, "t4_clr");

    for (int n = 0; n < 6; n++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      send(2, d, 0, 1'b0, sv, BIT_C);
      if (!sv) begin
        #(2 * BIT_C);
        rxl[2] = 1'b1;
        #(2 * BIT_C);
      end
      @(negedge clk); chk_all(2, "rnd");
      if ($urandom_range(0, 1) == 1) pop(2);
    end

    send(1, 8'h18, 2, 1'b1, 1'b1, BIT_A);
    @(negedge clk); chk_all(1, "t5_bad");
    pop(1);
    clr(1);
    send(1, 8'h18, 2, 1'b0, 1'b1, BIT_A);
    @(negedge clk); chk_all(1, "t5_good");

    d = 8'h18;
    rxl[0] = 1'b0;
    #(BIT_A);
    for (int b = 0; b < 3; b++) begin
      rxl[0] = d[b];
      #(BIT_A);
    end
    rxl[0] = d[3];
    #(BIT_A / 2);
    @(negedge clk);
    RST = 1'b0;
    #2;
    m_reset();
    chk_all(0, "t6_rst");
    chk_all(1, "t6_rst1");
    rxl[0] = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 8'h18, 0, 1'b0, 1'b1, 8507);
    @(negedge clk); chk_all(0, "t6_fast");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
